// File: rtl/ctrl_unit.sv
// ctrl_unit: instruction-sequencing FSM for the CSD datapath.
// Each cycle it names one shared-bus source (o_read_en) and the destination
// strobe(s) that capture the bus on the closing clock edge. Outputs are Moore
// functions of the state and the latched opcode/register field/zero flag. They
// are registered by computing them from the next state, so each output register
// changes on the same edge as the state it belongs to.
module ctrl_unit (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [15:0] i_ir,
    input  logic        i_z,
    output logic [3:0]  o_read_en,
    output logic [10:0] o_wr_en,
    output logic        o_pc_inc,
    output logic [1:0]  o_alu_op,
    output logic        o_im_rd,
    output logic        o_done
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_FETCH_IR = 3'd2,
        S_DECODE   = 3'd3,
        S_EXEC     = 3'd4,
        S_EXEC2    = 3'd5,
        S_HALT     = 3'd6
    } state_t;

    localparam logic [3:0] OP_MOVA  = 4'd1;
    localparam logic [3:0] OP_MOVR  = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_LDIM  = 4'd5;
    localparam logic [3:0] OP_LOAD  = 4'd6;
    localparam logic [3:0] OP_STORE = 4'd7;
    localparam logic [3:0] OP_LDAR  = 4'd8;
    localparam logic [3:0] OP_JMPZ  = 4'd9;
    localparam logic [3:0] OP_JMP   = 4'd10;
    localparam logic [3:0] OP_END   = 4'd15;

    // Bus source codes
    localparam logic [3:0] BUS_NONE = 4'd0;
    localparam logic [3:0] BUS_AC   = 4'd5;
    localparam logic [3:0] BUS_DM   = 4'd12;
    localparam logic [3:0] BUS_IM   = 4'd13;

    // Load-strobe bit positions
    localparam int WR_PC  = 0;
    localparam int WR_DAR = 1;
    localparam int WR_IR  = 2;
    localparam int WR_AC  = 3;
    localparam int WR_DM  = 10;

    localparam logic [1:0] ALU_PASS = 2'd0;
    localparam logic [1:0] ALU_ADD  = 2'd1;
    localparam logic [1:0] ALU_SUB  = 2'd2;

    state_t      r_state;
    logic [3:0]  r_op_q;
    logic [2:0]  r_rf_q;
    logic        r_z_q;
    logic [3:0]  r_read_en;
    logic [10:0] r_wr_en;
    logic        r_pc_inc;
    logic [1:0]  r_alu_op;
    logic        r_im_rd;
    logic        r_done;

    state_t      w_state_next;
    logic [3:0]  w_op_next;
    logic [2:0]  w_rf_next;
    logic        w_z_next;
    logic [3:0]  w_read_en_next;
    logic [10:0] w_wr_en_next;
    logic        w_pc_inc_next;
    logic [1:0]  w_alu_op_next;
    logic        w_im_rd_next;
    logic        w_done_next;
    logic [3:0]  w_sel_src;
    logic [10:0] w_sel_wr;
    logic        w_unused;

    // Only the opcode and register field of IR matter here.
    assign w_unused = ^i_ir[11:3];

    // Register field k selects bus code 6+k and load strobe bit 4+k.
    assign w_sel_src = 4'd6 + {1'b0, w_rf_next};
    assign w_sel_wr  = 11'(1) << (4'd4 + {1'b0, w_rf_next});

    // Next state plus the opcode/field/flag latches captured in DECODE
    always_comb begin
        w_state_next = r_state;
        w_op_next    = r_op_q;
        w_rf_next    = r_rf_q;
        w_z_next     = r_z_q;
        case (r_state)
            S_IDLE:     if (i_start) w_state_next = S_FETCH;
            S_FETCH:    w_state_next = S_FETCH_IR;
            S_FETCH_IR: w_state_next = S_DECODE;
            S_DECODE: begin
                w_op_next = i_ir[15:12];
                w_rf_next = i_ir[2:0];
                w_z_next  = i_z;
                case (i_ir[15:12])
                    OP_MOVA, OP_MOVR, OP_ADD, OP_SUB:
                        // Fields 6 and 7 name no register: skip the instruction
                        w_state_next = (i_ir[2:1] == 2'b11) ? S_FETCH : S_EXEC;
                    OP_LDIM, OP_LOAD, OP_STORE, OP_LDAR, OP_JMPZ, OP_JMP:
                        w_state_next = S_EXEC;
                    OP_END:
                        w_state_next = S_HALT;
                    default:
                        w_state_next = S_FETCH;
                endcase
            end
            S_EXEC: begin
                if ((r_op_q == OP_LDIM) || (r_op_q == OP_JMP) ||
                    ((r_op_q == OP_JMPZ) && r_z_q))
                    w_state_next = S_EXEC2;
                else
                    w_state_next = S_FETCH;
            end
            S_EXEC2:    w_state_next = S_FETCH;
            S_HALT:     w_state_next = S_HALT;
            default:    w_state_next = S_IDLE;
        endcase
    end

    // Moore outputs of the state being entered, using the latches being entered
    always_comb begin
        w_read_en_next = BUS_NONE;
        w_wr_en_next   = '0;
        w_pc_inc_next  = 1'b0;
        w_alu_op_next  = ALU_PASS;
        w_im_rd_next   = 1'b0;
        w_done_next    = 1'b0;
        case (w_state_next)
            S_FETCH: w_im_rd_next = 1'b1;
            S_FETCH_IR: begin
                w_read_en_next       = BUS_IM;
                w_wr_en_next[WR_IR]  = 1'b1;
                w_pc_inc_next        = 1'b1;
            end
            S_EXEC: begin
                case (w_op_next)
                    OP_MOVA: begin
                        w_read_en_next = BUS_AC;
                        w_wr_en_next   = w_sel_wr;
                    end
                    OP_MOVR, OP_ADD, OP_SUB: begin
                        w_read_en_next      = w_sel_src;
                        w_wr_en_next[WR_AC] = 1'b1;
                        w_alu_op_next       = (w_op_next == OP_ADD) ? ALU_ADD :
                                              (w_op_next == OP_SUB) ? ALU_SUB : ALU_PASS;
                    end
                    OP_LOAD: begin
                        w_read_en_next      = BUS_DM;
                        w_wr_en_next[WR_AC] = 1'b1;
                    end
                    OP_STORE: begin
                        w_read_en_next      = BUS_AC;
                        w_wr_en_next[WR_DM] = 1'b1;
                    end
                    OP_LDAR: begin
                        w_read_en_next       = BUS_AC;
                        w_wr_en_next[WR_DAR] = 1'b1;
                    end
                    OP_LDIM, OP_JMP: w_im_rd_next = 1'b1;
                    OP_JMPZ: begin
                        // Taken: read the target word; not taken: step over it
                        w_im_rd_next  = w_z_next;
                        w_pc_inc_next = ~w_z_next;
                    end
                    default: ;
                endcase
            end
            S_EXEC2: begin
                w_read_en_next = BUS_IM;
                if (w_op_next == OP_LDIM) begin
                    w_wr_en_next[WR_AC] = 1'b1;
                    w_pc_inc_next       = 1'b1;
                end else begin
                    // Jump target loads PC; no increment so the load wins
                    w_wr_en_next[WR_PC] = 1'b1;
                end
            end
            S_HALT: w_done_next = 1'b1;
            default: ;
        endcase
    end

    // State, instruction latches and registered outputs; reset clears all at once
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_op_q    <= '0;
            r_rf_q    <= '0;
            r_z_q     <= 1'b0;
            r_read_en <= '0;
            r_wr_en   <= '0;
            r_pc_inc  <= 1'b0;
            r_alu_op  <= '0;
            r_im_rd   <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_op_q    <= w_op_next;
            r_rf_q    <= w_rf_next;
            r_z_q     <= w_z_next;
            r_read_en <= w_read_en_next;
            r_wr_en   <= w_wr_en_next;
            r_pc_inc  <= w_pc_inc_next;
            r_alu_op  <= w_alu_op_next;
            r_im_rd   <= w_im_rd_next;
            r_done    <= w_done_next;
        end
    end

    assign o_read_en = r_read_en;
    assign o_wr_en   = r_wr_en;
    assign o_pc_inc  = r_pc_inc;
    assign o_alu_op  = r_alu_op;
    assign o_im_rd   = r_im_rd;
    assign o_done    = r_done;

endmodule

// File: tb/tb_ctrl_unit.sv
// tb_ctrl_unit: instruction-level reference model feeds a per-cycle expected
// output queue; an independent monitor compares every cycle on the falling edge.
module tb_ctrl_unit;

    typedef struct packed {
        logic [3:0]  read_en;
        logic [10:0] wr_en;
        logic        pc_inc;
        logic [1:0]  alu_op;
        logic        im_rd;
        logic        done;
    } out_t;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic [15:0] i_ir = '0;
    logic        i_z = 1'b0;
    logic [3:0]  o_read_en;
    logic [10:0] o_wr_en;
    logic        o_pc_inc;
    logic [1:0]  o_alu_op;
    logic        o_im_rd;
    logic        o_done;

    out_t exp_q[$];
    out_t act_v;
    out_t exp_v;
    bit   mon_on = 1'b0;
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;

    ctrl_unit dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_start   (i_start),
        .i_ir      (i_ir),
        .i_z       (i_z),
        .o_read_en (o_read_en),
        .o_wr_en   (o_wr_en),
        .o_pc_inc  (o_pc_inc),
        .o_alu_op  (o_alu_op),
        .o_im_rd   (o_im_rd),
        .o_done    (o_done)
    );

    always #5 i_clk = ~i_clk;

    // Build one cycle's expected outputs: bus source, load target (-1 none), etc.
    function automatic out_t mk(input int src, input int dst, input bit inc,
                                input int alu, input bit rd, input bit dn);
        out_t o;
        o.read_en = 4'(src);
        o.wr_en   = (dst < 0) ? 11'd0 : (11'(1) << dst);
        o.pc_inc  = inc;
        o.alu_op  = 2'(alu);
        o.im_rd   = rd;
        o.done    = dn;
        return o;
    endfunction

    // Reference model: expected per-cycle behaviour of one whole instruction
    task automatic model_instr(input logic [15:0] ins, input bit zd, output int n);
        int op;
        int rf;
        bit rf_ok;
        op    = int'(ins[15:12]);
        rf    = int'(ins[2:0]);
        rf_ok = (rf <= 5);
        exp_q.push_back(mk(0, -1, 0, 0, 1, 0));   // fetch: read IM at PC
        exp_q.push_back(mk(13, 2, 1, 0, 0, 0));   // IM -> IR, PC++
        exp_q.push_back(mk(0, -1, 0, 0, 0, 0));   // decode
        n = 3;
        case (op)
            1: if (rf_ok) begin exp_q.push_back(mk(5, 4 + rf, 0, 0, 0, 0)); n = 4; end
            2: if (rf_ok) begin exp_q.push_back(mk(6 + rf, 3, 0, 0, 0, 0)); n = 4; end
            3: if (rf_ok) begin exp_q.push_back(mk(6 + rf, 3, 0, 1, 0, 0)); n = 4; end
            4: if (rf_ok) begin exp_q.push_back(mk(6 + rf, 3, 0, 2, 0, 0)); n = 4; end
            6: begin exp_q.push_back(mk(12, 3, 0, 0, 0, 0)); n = 4; end
            7: begin exp_q.push_back(mk(5, 10, 0, 0, 0, 0)); n = 4; end
            8: begin exp_q.push_back(mk(5, 1, 0, 0, 0, 0)); n = 4; end
            5: begin
                exp_q.push_back(mk(0, -1, 0, 0, 1, 0));
                exp_q.push_back(mk(13, 3, 1, 0, 0, 0));
                n = 5;
            end
            9, 10: begin
                if (op == 10 || zd) begin
                    exp_q.push_back(mk(0, -1, 0, 0, 1, 0));
                    exp_q.push_back(mk(13, 0, 0, 0, 0, 0));
                    n = 5;
                end else begin
                    exp_q.push_back(mk(0, -1, 1, 0, 0, 0));
                    n = 4;
                end
            end
            default: ;
        endcase
    endtask

    // Monitor: every cycle is a transaction; pop and compare on the falling edge
    always @(negedge i_clk) begin
        if (mon_on) begin
            cyc++;
            checks++;
            act_v = {o_read_en, o_wr_en, o_pc_inc, o_alu_op, o_im_rd, o_done};
            if (exp_q.size() == 0) begin
                $display("FAIL underflow cycle %0d: output read_en=%0d wr_en=%h with nothing expected",
                         cyc, o_read_en, o_wr_en);
            end else begin
                exp_v = exp_q.pop_front();
                if (act_v !== exp_v)
                    $display("FAIL outputs cycle %0d: got read_en=%0d wr_en=%h pc_inc=%b alu_op=%0d im_rd=%b done=%b, expected read_en=%0d wr_en=%h pc_inc=%b alu_op=%0d im_rd=%b done=%b",
                             cyc, act_v.read_en, act_v.wr_en, act_v.pc_inc, act_v.alu_op, act_v.im_rd, act_v.done,
                             exp_v.read_en, exp_v.wr_en, exp_v.pc_inc, exp_v.alu_op, exp_v.im_rd, exp_v.done);
                else
                    passes++;
            end
        end
    end

    // Called just after a rising edge: hold reset two cycles, then two idle cycles
    task automatic do_reset();
        i_rst_n = 1'b0;
        i_start = 1'b0;
        repeat (2) exp_q.push_back(mk(0, -1, 0, 0, 0, 0));
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        repeat (2) exp_q.push_back(mk(0, -1, 0, 0, 0, 0));
        repeat (2) @(posedge i_clk);
        #1;
        $display("reset: idle after release");
    endtask

    // One idle cycle with start high; leaves the FSM in FETCH
    task automatic go();
        i_start = 1'b1;
        exp_q.push_back(mk(0, -1, 0, 0, 0, 0));
        @(posedge i_clk);
        #1;
        i_start = 1'($urandom);
    endtask

    // Run one instruction from FETCH; z may change after DECODE
    task automatic exec_instr(input logic [15:0] ins, input bit zd, input bit ze);
        int n;
        model_instr(ins, zd, n);
        i_ir    = ins;
        i_z     = zd;
        i_start = 1'($urandom);
        repeat (3) @(posedge i_clk);
        #1;
        i_z = ze;
        if (n > 3) repeat (n - 3) @(posedge i_clk);
        #1;
        $display("instr ir=%h z=%0b cycles=%0d", ins, zd, n);
    endtask

    initial begin
        logic [15:0] rin;
        int          n;
        @(posedge i_clk);
        #1;
        mon_on = 1'b1;
        do_reset();
        go();

        // Abort a STORE in EXEC: outputs drop at once, no DM write follows
        exp_q.push_back(mk(0, -1, 0, 0, 1, 0));
        exp_q.push_back(mk(13, 2, 1, 0, 0, 0));
        exp_q.push_back(mk(0, -1, 0, 0, 0, 0));
        i_ir = 16'h7000;
        repeat (3) @(posedge i_clk);
        #1;
        do_reset();
        $display("instr ir=7000 aborted by reset in EXEC");
        go();

        // Directed cases
        exec_instr(16'h3003, 1'b0, 1'b0);
        exec_instr(16'h9000, 1'b1, 1'b0);
        exec_instr(16'h9000, 1'b0, 1'b1);
        exec_instr(16'h1007, 1'b0, 1'b0);
        exec_instr(16'h5000, 1'b0, 1'b0);
        exec_instr(16'hA000, 1'b0, 1'b0);
        exec_instr(16'h0000, 1'b1, 1'b1);
        exec_instr(16'hB005, 1'b0, 1'b0);
        exec_instr(16'h2005, 1'b0, 1'b0);
        exec_instr(16'h4000, 1'b0, 1'b0);
        exec_instr(16'h6000, 1'b0, 1'b0);
        exec_instr(16'h8000, 1'b0, 1'b0);
        exec_instr(16'h1001, 1'b0, 1'b0);

        // Random program (no END so the run keeps going)
        for (int k = 0; k < 200; k++) begin
            rin = 16'($urandom);
            rin[15:12] = 4'($urandom_range(0, 14));
            exec_instr(rin, 1'($urandom), 1'($urandom));
        end

        // END: done from the cycle after DECODE, held with start toggling
        model_instr(16'hF000, 1'b0, n);
        repeat (20) exp_q.push_back(mk(0, -1, 0, 0, 0, 1));
        i_ir = 16'hF000;
        repeat (3) @(posedge i_clk);
        for (int k = 0; k < 20; k++) begin
            #1;
            i_start = ~i_start;
            @(posedge i_clk);
        end
        #1;
        $display("instr ir=F000 halted for 20 cycles");
        do_reset();
        go();
        exec_instr(16'h7000, 1'b0, 1'b0);

        mon_on = 1'b0;
        checks++;
        if (exp_q.size() != 0)
            $display("FAIL drain: %0d expected cycles left unchecked, required 0", exp_q.size());
        else
            passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
